// File: rtl/clock_pkg.sv
// Shared types and constants for the clock time-set controller.
// Used by clock_set_ctrl (optional auto-repeat via CLOCK_SET_AUTOREPEAT_EN).
package clock_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        COMMIT   = 2'd3
    } state_t;

    localparam logic [1:0] FIELD_RUN  = 2'd0;
    localparam logic [1:0] FIELD_HOUR = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;

    localparam logic [3:0] HOUR_MIN   = 4'd1;
    localparam logic [3:0] HOUR_MAX   = 4'd12;
    localparam logic [5:0] MIN_MAX    = 6'd59;

    // Out-of-range hours fold back to 1 so a corrupted shadow value self-heals.
    function automatic logic [3:0] next_hour(input logic [3:0] hour);
        if ((hour >= HOUR_MAX) || (hour < HOUR_MIN)) begin
            return HOUR_MIN;
        end else begin
            return hour + 4'd1;
        end
    endfunction

    function automatic logic [5:0] next_min(input logic [5:0] minute);
        if (minute >= MIN_MAX) begin
            return 6'd0;
        end else begin
            return minute + 6'd1;
        end
    endfunction

endpackage

// File: rtl/clock_set_ctrl_debounce.sv
// Button conditioning: 2-flop synchroniser, stability counter and rise pulse.
// All state freezes while ena is low; the press pulse is suppressed then.
module btn_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

    logic       meta_r;
    logic       sync_r;
    logic       level_r;
    logic       press_r;
    logic [7:0] cnt_r;

    // Synchronise, count consecutive differing samples, flip level on the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r  <= 1'b0;
            sync_r  <= 1'b0;
            level_r <= 1'b0;
            press_r <= 1'b0;
            cnt_r   <= 8'd0;
        end else if (!ena) begin
            press_r <= 1'b0;
        end else begin
            meta_r <= raw;
            sync_r <= meta_r;
            if (sync_r != level_r) begin
                if (cnt_r >= DEB_LAST) begin
                    level_r <= sync_r;
                    press_r <= sync_r;
                    cnt_r   <= 8'd0;
                end else begin
                    press_r <= 1'b0;
                    cnt_r   <= cnt_r + 8'd1;
                end
            end else begin
                press_r <= 1'b0;
                cnt_r   <= 8'd0;
            end
        end
    end

    assign level = level_r;
    assign press = press_r;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-set controller: button debounce, RUN/SET_HOUR/SET_MIN/COMMIT FSM, shadow registers.
// Define CLOCK_SET_AUTOREPEAT_EN to enable INC auto-repeat while the button is held.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int DEB_CYCLES   = 4,
    parameter int TIMEOUT_SEC  = 30
`ifdef CLOCK_SET_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY = 16,
    parameter int REPEAT_RATE  = 4
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       tick_sec,
    input  logic [3:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic       cur_pm,
    output logic       run_en,
    output logic       load,
    output logic [3:0] load_hour,
    output logic [5:0] load_min,
    output logic       load_pm,
    output logic [1:0] set_field,
    output logic       blink
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_SEC - 1);

    logic mode_level_s, mode_press_s;
    logic inc_level_s, inc_press_s, inc_step_s;
    logic in_set_s;
    logic mode_evt_s, inc_evt_s;
    logic unused_s;

    state_t     state_r, state_n;
    logic [3:0] hour_r, hour_n;
    logic [5:0] min_r, min_n;
    logic       pm_r, pm_n;
    logic       blink_r, blink_n;
    logic [7:0] tcnt_r, tcnt_n;
    logic       run_en_r, load_r;
    logic [1:0] set_field_r;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk(clk), .rst_n(rst_n), .ena(ena), .raw(btn_mode),
        .level(mode_level_s), .press(mode_press_s)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
        .clk(clk), .rst_n(rst_n), .ena(ena), .raw(btn_inc),
        .level(inc_level_s), .press(inc_press_s)
    );

    assign in_set_s = (state_r == SET_HOUR) || (state_r == SET_MIN);

`ifdef CLOCK_SET_AUTOREPEAT_EN
    localparam logic [7:0] REP_DELAY_V = 8'(REPEAT_DELAY);
    localparam logic [7:0] REP_RATE_V  = 8'(REPEAT_RATE);

    logic [7:0] rep_cnt_r;
    logic       rep_armed_r;
    logic       rep_fire_s;

    // rep_cnt_r counts cycles since the press; first fire after the delay, then every rate.
    assign rep_fire_s = inc_level_s && in_set_s &&
                        (rep_armed_r ? (rep_cnt_r == REP_RATE_V) : (rep_cnt_r == REP_DELAY_V));

    // Auto-repeat pacing counter, cleared whenever INC is released or editing ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_r   <= 8'd0;
            rep_armed_r <= 1'b0;
        end else if (!ena) begin
            rep_cnt_r   <= rep_cnt_r;
        end else if (!inc_level_s || !in_set_s) begin
            rep_cnt_r   <= 8'd0;
            rep_armed_r <= 1'b0;
        end else if (rep_fire_s) begin
            rep_cnt_r   <= 8'd1;
            rep_armed_r <= 1'b1;
        end else begin
            rep_cnt_r   <= rep_cnt_r + 8'd1;
        end
    end

    assign inc_step_s = inc_press_s | rep_fire_s;
`else
    assign inc_step_s = inc_press_s;
`endif

    assign unused_s   = mode_level_s ^ inc_level_s;
    assign mode_evt_s = ena & mode_press_s;
    assign inc_evt_s  = ena & inc_step_s & ~mode_press_s;

    // Next-state and shadow-register update logic.
    always_comb begin
        state_n = state_r;
        hour_n  = hour_r;
        min_n   = min_r;
        pm_n    = pm_r;
        blink_n = blink_r;
        tcnt_n  = tcnt_r;
        if (!ena) begin
            state_n = state_r;
        end else begin
            case (state_r)
                RUN: begin
                    if (mode_evt_s) begin
                        hour_n  = cur_hour;
                        min_n   = cur_min;
                        pm_n    = cur_pm;
                        tcnt_n  = 8'd0;
                        state_n = SET_HOUR;
                    end else begin
                        tcnt_n  = 8'd0;
                    end
                end
                SET_HOUR, SET_MIN: begin
                    if (tick_sec) begin
                        blink_n = ~blink_r;
                    end else begin
                        blink_n = blink_r;
                    end
                    if (mode_evt_s) begin
                        tcnt_n  = 8'd0;
                        state_n = (state_r == SET_HOUR) ? SET_MIN : COMMIT;
                    end else if (inc_evt_s) begin
                        tcnt_n = 8'd0;
                        if (state_r == SET_HOUR) begin
                            hour_n = next_hour(hour_r);
                            pm_n   = (hour_r == 4'd11) ? ~pm_r : pm_r;
                        end else begin
                            min_n  = next_min(min_r);
                        end
                    end else if (tick_sec) begin
                        if (tcnt_r >= TIMEOUT_LAST) begin
                            tcnt_n  = 8'd0;
                            state_n = RUN;
                        end else begin
                            tcnt_n  = tcnt_r + 8'd1;
                        end
                    end else begin
                        tcnt_n = tcnt_r;
                    end
                end
                COMMIT: begin
                    state_n = RUN;
                end
                default: begin
                    state_n = RUN;
                end
            endcase
        end
        // Blink phase is only meaningful while a field is being edited.
        if ((state_n != SET_HOUR) && (state_n != SET_MIN)) begin
            blink_n = 1'b0;
        end else begin
            blink_n = blink_n;
        end
    end

    // State, shadow and registered output update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= RUN;
            hour_r      <= HOUR_MAX;
            min_r       <= 6'd0;
            pm_r        <= 1'b0;
            blink_r     <= 1'b0;
            tcnt_r      <= 8'd0;
            run_en_r    <= 1'b1;
            load_r      <= 1'b0;
            set_field_r <= FIELD_RUN;
        end else begin
            state_r  <= state_n;
            hour_r   <= hour_n;
            min_r    <= min_n;
            pm_r     <= pm_n;
            blink_r  <= blink_n;
            tcnt_r   <= tcnt_n;
            run_en_r <= (state_n == RUN);
            load_r   <= ena && (state_n == COMMIT) && (state_r != COMMIT);
            case (state_n)
                SET_HOUR: set_field_r <= FIELD_HOUR;
                SET_MIN:  set_field_r <= FIELD_MIN;
                default:  set_field_r <= FIELD_RUN;
            endcase
        end
    end

    assign run_en    = run_en_r;
    assign load      = load_r;
    assign load_hour = hour_r;
    assign load_min  = min_r;
    assign load_pm   = pm_r;
    assign set_field = set_field_r;
    assign blink     = blink_r;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed self-checking bench for clock_set_ctrl (default parameters).
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       tick_sec = 1'b0;
    logic [3:0] cur_hour = 4'd1;
    logic [5:0] cur_min = 6'd0;
    logic       cur_pm = 1'b0;
    logic       run_en, load, load_pm, blink;
    logic [3:0] load_hour;
    logic [5:0] load_min;
    logic [1:0] set_field;

    int checks = 0;
    int errors = 0;
    int load_cnt = 0;
    int snap;

    clock_set_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .tick_sec(tick_sec), .cur_hour(cur_hour), .cur_min(cur_min), .cur_pm(cur_pm),
        .run_en(run_en), .load(load), .load_hour(load_hour), .load_min(load_min),
        .load_pm(load_pm), .set_field(set_field), .blink(blink)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load === 1'b1) load_cnt <= load_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; tick_sec = 1'b0; ena = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic press_mode();
        btn_mode = 1'b1; tick(7);
        btn_mode = 1'b0; tick(8);
    endtask

    task automatic press_inc();
        btn_inc = 1'b1; tick(7);
        btn_inc = 1'b0; tick(8);
    endtask

    task automatic pulse_tick();
        tick_sec = 1'b1; tick(1);
        tick_sec = 1'b0; tick(2);
    endtask

    task automatic enter_set(input logic [3:0] h, input logic [5:0] m, input logic p);
        do_reset();
        cur_hour = h; cur_min = m; cur_pm = p;
        press_mode();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        checks++; if ({run_en, load, load_hour, load_min, load_pm, set_field, blink} !== {1'b1, 1'b0, 4'd12, 6'd0, 1'b0, 2'd0, 1'b0}) begin
            errors++; $display("FAIL reset_values got run_en=%0b load=%0b %0d:%0d pm=%0b field=%0d blink=%0b exp 1 0 12:0 0 0 0",
                run_en, load, load_hour, load_min, load_pm, set_field, blink);
        end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_enter_set();
        do_reset();
        cur_hour = 4'd11; cur_min = 6'd59; cur_pm = 1'b1;
        btn_mode = 1'b1;
        tick(6);
        checks++; if (set_field !== 2'd0 || run_en !== 1'b1) begin
            errors++; $display("FAIL enter_early got field=%0d run_en=%0b exp 0 1", set_field, run_en);
        end
        tick(1);
        checks++; if (set_field !== 2'd1 || run_en !== 1'b0) begin
            errors++; $display("FAIL enter_latency got field=%0d run_en=%0b exp 1 0", set_field, run_en);
        end
        checks++; if ({load_hour, load_min, load_pm} !== {4'd11, 6'd59, 1'b1}) begin
            errors++; $display("FAIL enter_capture got %0d:%0d pm=%0b exp 11:59 pm=1", load_hour, load_min, load_pm);
        end
        btn_mode = 1'b0;
        tick(8);
    endtask

    task automatic test_edit_commit();
        enter_set(4'd11, 6'd59, 1'b0);
        press_inc();
        checks++; if ({load_hour, load_pm} !== {4'd12, 1'b1}) begin
            errors++; $display("FAIL inc_11_to_12 got %0d pm=%0b exp 12 pm=1", load_hour, load_pm);
        end
        press_inc();
        checks++; if ({load_hour, load_pm} !== {4'd1, 1'b1}) begin
            errors++; $display("FAIL inc_12_to_1 got %0d pm=%0b exp 1 pm=1", load_hour, load_pm);
        end
        press_mode();
        checks++; if (set_field !== 2'd2) begin
            errors++; $display("FAIL to_set_min got field=%0d exp 2", set_field);
        end
        press_inc();
        checks++; if ({load_hour, load_min} !== {4'd1, 6'd0}) begin
            errors++; $display("FAIL min_wrap got %0d:%0d exp 1:0", load_hour, load_min);
        end
        snap = load_cnt;
        btn_mode = 1'b1;
        tick(6);
        checks++; if (load !== 1'b0) begin
            errors++; $display("FAIL load_early got %0b exp 0", load);
        end
        tick(1);
        checks++; if ({load, run_en, load_hour, load_min, load_pm} !== {1'b1, 1'b0, 4'd1, 6'd0, 1'b1}) begin
            errors++; $display("FAIL commit_load got load=%0b run_en=%0b %0d:%0d pm=%0b exp 1 0 1:0 1",
                load, run_en, load_hour, load_min, load_pm);
        end
        tick(1);
        checks++; if ({load, run_en, set_field} !== {1'b0, 1'b1, 2'd0}) begin
            errors++; $display("FAIL commit_end got load=%0b run_en=%0b field=%0d exp 0 1 0", load, run_en, set_field);
        end
        btn_mode = 1'b0;
        tick(10);
        checks++; if (load_cnt - snap !== 1) begin
            errors++; $display("FAIL commit_single got %0d pulses exp 1", load_cnt - snap);
        end
    endtask

    task automatic test_glitch();
        enter_set(4'd5, 6'd10, 1'b0);
        btn_inc = 1'b1; tick(1);
        btn_inc = 1'b0; tick(10);
        btn_inc = 1'b1; tick(3);
        btn_inc = 1'b0; tick(10);
        checks++; if ({load_hour, set_field} !== {4'd5, 2'd1}) begin
            errors++; $display("FAIL glitch got hour=%0d field=%0d exp 5 1", load_hour, set_field);
        end
    endtask

    task automatic test_ena();
        enter_set(4'd5, 6'd10, 1'b0);
        ena = 1'b0;
        btn_inc = 1'b1; tick(20);
        btn_inc = 1'b0; tick(5);
        ena = 1'b1; tick(10);
        checks++; if ({load_hour, set_field} !== {4'd5, 2'd1}) begin
            errors++; $display("FAIL ena_hold got hour=%0d field=%0d exp 5 1", load_hour, set_field);
        end
    endtask

    task automatic test_timeout();
        enter_set(4'd3, 6'd20, 1'b1);
        press_mode();
        snap = load_cnt;
        pulse_tick();
        checks++; if (blink !== 1'b1) begin
            errors++; $display("FAIL blink_toggle got %0b exp 1", blink);
        end
        for (int i = 1; i < 29; i++) pulse_tick();
        checks++; if ({set_field, run_en} !== {2'd2, 1'b0}) begin
            errors++; $display("FAIL timeout_early got field=%0d run_en=%0b exp 2 0", set_field, run_en);
        end
        pulse_tick();
        checks++; if ({set_field, run_en, blink} !== {2'd0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL timeout_exit got field=%0d run_en=%0b blink=%0b exp 0 1 0", set_field, run_en, blink);
        end
        checks++; if (load_cnt - snap !== 0) begin
            errors++; $display("FAIL timeout_noload got %0d pulses exp 0", load_cnt - snap);
        end
    endtask

    task automatic test_priority_reset();
        enter_set(4'd7, 6'd45, 1'b0);
        btn_mode = 1'b1; btn_inc = 1'b1; tick(7);
        btn_mode = 1'b0; btn_inc = 1'b0; tick(8);
        checks++; if ({set_field, load_hour, load_min} !== {2'd2, 4'd7, 6'd45}) begin
            errors++; $display("FAIL mode_priority got field=%0d %0d:%0d exp 2 7:45", set_field, load_hour, load_min);
        end
        press_inc();
        checks++; if (load_min !== 6'd46) begin
            errors++; $display("FAIL min_step got %0d exp 46", load_min);
        end
        snap = load_cnt;
        rst_n = 1'b0; #1;
        checks++; if ({run_en, load, load_hour, load_min, load_pm, set_field} !== {1'b1, 1'b0, 4'd12, 6'd0, 1'b0, 2'd0}) begin
            errors++; $display("FAIL midedit_reset got run_en=%0b load=%0b %0d:%0d pm=%0b field=%0d exp 1 0 12:0 0 0",
                run_en, load, load_hour, load_min, load_pm, set_field);
        end
        tick(2);
        rst_n = 1'b1;
        tick(5);
        checks++; if (load_cnt - snap !== 0) begin
            errors++; $display("FAIL reset_noload got %0d pulses exp 0", load_cnt - snap);
        end
    endtask

    task automatic test_autorepeat();
        logic [5:0] exp_min;
`ifdef CLOCK_SET_AUTOREPEAT_EN
        exp_min = 6'd11;
`else
        exp_min = 6'd1;
`endif
        enter_set(4'd4, 6'd0, 1'b0);
        press_mode();
        btn_inc = 1'b1; tick(16 + 10 * 4);
        btn_inc = 1'b0; tick(10);
        checks++; if (load_min !== exp_min) begin
            errors++; $display("FAIL hold_inc got min=%0d exp %0d", load_min, exp_min);
        end
    endtask

    initial begin
        test_reset();
        test_enter_set();
        test_edit_commit();
        test_glitch();
        test_ena();
        test_timeout();
        test_priority_reset();
        test_autorepeat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
